// File: rtl/character_up_down_mover.sv
// Vertical motion of a sprite over a tile map: gravity, one-shot jumps, ceiling and floor stops.
// One-edge latency from tile/position/jump inputs to char_y, airborne and jump_ack; no backpressure.
module character_up_down_mover #(
  parameter int BDR             = 0,
  parameter int SKY             = 1,
  parameter int BLK             = 2,
  parameter int GND             = 3,
  parameter int CHARACTER_WIDTH = 42,
  parameter int SCREEN_HEIGHT   = 480,
  parameter int BLOCK_WIDTH     = 40,
  parameter int JUMP_HEIGHT     = 120,
  parameter int START_Y         = 358
) (
  input  logic                      movement_clock,
  input  logic                      reset,
  input  logic [11:0][16:0][7:0]    background,
  input  logic signed [31:0]        char_x,
  input  logic                      jump_req,
  output logic signed [31:0]        char_y,
  output logic                      airborne,
  output logic                      jump_ack
);

  localparam int RW = $clog2(JUMP_HEIGHT + 1);
  localparam logic [RW-1:0] JUMP_MAX = RW'(JUMP_HEIGHT);

  typedef enum logic [1:0] {GROUNDED, RISING, FALLING} state_t;

  state_t             state_q, state_d;
  logic signed [31:0] char_y_q, char_y_d;
  logic [RW-1:0]      rise_cnt_q, rise_cnt_d;
  logic               armed_q, armed_d;
  logic               airborne_q;
  logic               jump_ack_q, jump_ack_d;

  logic [4:0]         col_l, col_r;
  logic [3:0]         row_up, row_dn;
  logic               solid_up, solid_dn;

  function automatic logic [4:0] clamp_col(input logic signed [31:0] v);
    if (v < 0)       return 5'd0;
    else if (v > 16) return 5'd16;
    else             return v[4:0];
  endfunction

  function automatic logic [3:0] clamp_row(input logic signed [31:0] v);
    if (v < 0)       return 4'd0;
    else if (v > 11) return 4'd11;
    else             return v[3:0];
  endfunction

  // Open codes win if a tile table ever aliases an open code onto a solid one.
  function automatic logic tile_solid(input logic [7:0] code);
    return ((code == 8'(BLK)) || (code == 8'(GND))) &&
           (code != 8'(SKY)) && (code != 8'(BDR));
  endfunction

  assign col_l  = clamp_col(char_x / BLOCK_WIDTH);
  assign col_r  = clamp_col((char_x + CHARACTER_WIDTH - 1) / BLOCK_WIDTH);
  assign row_up = clamp_row((char_y_q - 1) / BLOCK_WIDTH);
  assign row_dn = clamp_row((char_y_q + CHARACTER_WIDTH) / BLOCK_WIDTH);

  // Screen edges are forced solid, so row clamping never decides a collision.
  assign solid_up = tile_solid(background[row_up][col_l]) |
                    tile_solid(background[row_up][col_r]) |
                    (char_y_q == 0);
  assign solid_dn = tile_solid(background[row_dn][col_l]) |
                    tile_solid(background[row_dn][col_r]) |
                    (char_y_q + CHARACTER_WIDTH >= SCREEN_HEIGHT);

  always_comb begin
    state_d    = state_q;
    char_y_d   = char_y_q;
    rise_cnt_d = rise_cnt_q;
    armed_d    = armed_q | ~jump_req;
    jump_ack_d = 1'b0;
    case (state_q)
      GROUNDED: begin
        if (!solid_dn) begin
          state_d = FALLING;
        end else if (jump_req && armed_q && !solid_up) begin
          state_d    = RISING;
          rise_cnt_d = '0;
          armed_d    = 1'b0;
          jump_ack_d = 1'b1;
        end
      end
      RISING: begin
        if (solid_up || (rise_cnt_q == JUMP_MAX)) begin
          state_d = FALLING;
        end else begin
          char_y_d   = char_y_q - 1;
          rise_cnt_d = rise_cnt_q + 1'b1;
        end
      end
      FALLING: begin
        if (solid_dn) state_d = GROUNDED;
        else          char_y_d = char_y_q + 1;
      end
      default: state_d = FALLING;
    endcase
  end

  always_ff @(posedge movement_clock or negedge reset) begin
    if (!reset) begin
      state_q    <= FALLING;
      char_y_q   <= START_Y;
      rise_cnt_q <= '0;
      armed_q    <= 1'b0;
      airborne_q <= 1'b1;
      jump_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      char_y_q   <= char_y_d;
      rise_cnt_q <= rise_cnt_d;
      armed_q    <= armed_d;
      airborne_q <= (state_d != GROUNDED);
      jump_ack_q <= jump_ack_d;
    end
  end

  assign char_y   = char_y_q;
  assign airborne = airborne_q;
  assign jump_ack = jump_ack_q;

endmodule

// File: tb/tb_character_up_down_mover.sv
// Scoreboard bench: stimulus pushes reference-model expectations, an edge monitor pops and compares.
module tb_character_up_down_mover;

  localparam int BW = 40, CW = 42, SH = 480, JH = 120, SY = 358;
  localparam int BDR = 0, SKY = 1, BLK = 2, GND = 3;
  localparam int M_GROUND = 0, M_RISE = 1, M_FALL = 2;

  logic                   clk;
  logic                   reset;
  logic [11:0][16:0][7:0] bg;
  logic signed [31:0]     char_x;
  logic                   jump_req;
  logic signed [31:0]     char_y;
  logic                   airborne;
  logic                   jump_ack;

  int tile [12][17];

  character_up_down_mover dut (
    .movement_clock(clk),
    .reset         (reset),
    .background    (bg),
    .char_x        (char_x),
    .jump_req      (jump_req),
    .char_y        (char_y),
    .airborne      (airborne),
    .jump_ack      (jump_ack)
  );

  always_comb begin
    bg = '0;
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 17; c++)
        bg[r][c] = tile[r][c][7:0];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int y;
    bit air;
    bit ack;
  } exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int ack_seen = 0;
  int min_y    = 1000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model: position plus a jump apex target, no rise counter.
  int m_mode, m_y, m_apex;
  bit m_armed;

  function automatic int clampc(input int v);
    return (v < 0) ? 0 : (v > 16) ? 16 : v;
  endfunction

  function automatic bit solid_at(input int r, input int x);
    int a, b;
    if (r < 0 || r > 11) return 1'b0;
    a = tile[r][clampc(x / BW)];
    b = tile[r][clampc((x + CW - 1) / BW)];
    return (a == BLK || a == GND || b == BLK || b == GND);
  endfunction

  task automatic model_reset();
    m_mode  = M_FALL;
    m_y     = SY;
    m_armed = 1'b0;
  endtask

  task automatic model_step(input int x, input bit jr);
    bit   up, dn;
    exp_t e;
    up = (m_y == 0) || solid_at((m_y - 1) / BW, x);
    dn = (m_y + CW >= SH) || solid_at((m_y + CW) / BW, x);
    e.ack = 1'b0;
    if (m_mode == M_GROUND) begin
      if (!dn) m_mode = M_FALL;
      else if (jr && m_armed && !up) begin
        m_mode  = M_RISE;
        m_apex  = m_y - JH;
        m_armed = 1'b0;
        e.ack   = 1'b1;
      end
    end else if (m_mode == M_RISE) begin
      if (up || m_y == m_apex) m_mode = M_FALL;
      else m_y = m_y - 1;
    end else begin
      if (dn) m_mode = M_GROUND;
      else m_y = m_y + 1;
    end
    if (!jr) m_armed = 1'b1;
    e.y   = m_y;
    e.air = (m_mode != M_GROUND);
    sb_q.push_back(e);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic drive(input int x, input bit jr);
    char_x   = x;
    jump_req = jr;
    model_step(x, jr);
    @(negedge clk);
  endtask

  task automatic run_until_ground(input int x, input bit jr, output int edges);
    edges = 0;
    while (m_mode != M_GROUND && edges < 600) begin
      drive(x, jr);
      edges++;
    end
    if (m_mode != M_GROUND) begin
      n_checks++;
      $display("FAIL ground_timeout: still airborne after %0d edges", edges);
    end
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    check({tag, "_rst_y"}, char_y, SY);
    check({tag, "_rst_air"}, airborne, 1);
    check({tag, "_rst_ack"}, jump_ack, 0);
    @(posedge clk);
    #2;
    check({tag, "_rst_hold_y"}, char_y, SY);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic default_map();
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 17; c++)
        tile[r][c] = (r == 10) ? GND : SKY;
  endtask

  task automatic random_map();
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 17; c++) begin
        if (r < 10)       tile[r][c] = ($urandom_range(0, 99) < 8) ? BLK : ($urandom_range(0, 1) ? SKY : BDR);
        else if (r == 10) tile[r][c] = ($urandom_range(0, 99) < 15) ? SKY : GND;
        else              tile[r][c] = $urandom_range(0, 1) ? GND : SKY;
      end
  endtask

  // Monitor: one expected entry per active edge while out of reset.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("char_y", char_y, e.y);
        check("airborne", airborne, e.air);
        check("jump_ack", jump_ack, e.ack);
        if (jump_ack === 1'b1) ack_seen++;
        if (char_y < min_y) min_y = char_y;
      end
    end
  end

  initial begin
    int edges, x;
    bit jr;
    reset    = 1'b1;
    jump_req = 1'b0;
    char_x   = 100;
    default_map();
    model_reset();
    #1;
    do_reset("init");

    // Settle onto the row-10 floor.
    drive(100, 0);
    check("settle_y", char_y, 358);
    check("settle_air", airborne, 0);
    repeat (3) drive(100, 0);

    // Full jump: 1 accept + 120 rises + 1 turn + 120 falls + 1 landing.
    ack_seen = 0; min_y = 1000;
    drive(100, 1);
    run_until_ground(100, 0, edges);
    check("jump_edges", edges + 1, 243);
    check("jump_apex", min_y, 238);
    check("jump_acks", ack_seen, 1);
    check("jump_land_y", char_y, 358);

    // Ceiling block over both columns stops the rise at 320.
    tile[7][2] = BLK; tile[7][3] = BLK;
    drive(100, 0);
    ack_seen = 0; min_y = 1000;
    drive(100, 1);
    run_until_ground(100, 0, edges);
    check("ceil_apex", min_y, 320);
    check("ceil_acks", ack_seen, 1);
    check("ceil_land_y", char_y, 358);
    tile[7][2] = SKY; tile[7][3] = SKY;

    // Held request re-arms only after a low cycle.
    ack_seen = 0;
    drive(100, 1);
    run_until_ground(100, 1, edges);
    repeat (10) drive(100, 1);
    check("held_single_ack", ack_seen, 1);
    drive(100, 0);
    drive(100, 1);
    check("rearm_ack", ack_seen, 2);
    run_until_ground(100, 0, edges);

    // Ledge: walk over a hole and drop to the screen floor.
    tile[10][6] = SKY; tile[10][7] = SKY;
    drive(240, 0);
    check("ledge_air", airborne, 1);
    check("ledge_y", char_y, 358);
    run_until_ground(240, 0, edges);
    check("floor_y", char_y, 438);
    check("floor_air", airborne, 0);
    default_map();

    // Mid-jump reset at char_y 300.
    do_reset("recover");
    drive(100, 0);
    drive(100, 1);
    edges = 0;
    while (m_y > 300 && edges < 200) begin
      drive(100, 0);
      edges++;
    end
    check("pre_reset_y", char_y, 300);
    do_reset("midjump");
    drive(100, 0);
    check("post_reset_y", char_y, 358);
    check("post_reset_air", airborne, 0);

    // Randomized maps, positions and requests.
    x = 100; jr = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (k % 500 == 250) random_map();
      if ($urandom_range(0, 9) == 0) x = int'($urandom_range(0, 750)) - 50;
      else x = x + int'($urandom_range(0, 4)) - 2;
      if ($urandom_range(0, 5) == 0) jr = ~jr;
      drive(x, jr);
    end

    repeat (2) @(negedge clk);
    check("sb_drain", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
